lfsr_5_checker: RTL
===================

# lfsr_5_checker

Receive-side companion to the 5-bit LFSR sequence generator (`top_lfsr_5`). It takes the serial bit stream produced by the Fibonacci/Galois generators and the output mux, one bit per valid cycle, and self-synchronises to the 31-bit m-sequence b[n] = b[n-5] XOR b[n-3] (x^5+x^3+1). Once locked, it regenerates the sequence locally, flags each bit error, counts errors, and drops lock when the error density exceeds a threshold.

## Interface
- `LOCK_CNT`, default 8: consecutive correct predictions required in VERIFY before declaring lock (1..31).
- `UNLOCK_ERR`, default 4: errors within one 31-bit window that force loss of lock (1..31).
- `CNT_W`, default 16: width of the saturating error counter.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `nrst`  in  1: reset, asynchronous, active-low.
- `bit_in`  in  1: received sequence bit; sampled only when `bit_valid`=1.
- `bit_valid`  in  1: qualifies `bit_in`; one bit per cycle maximum; gaps allowed.
- `clr_err`  in  1: synchronous clear of `err_count`.
- `locked`  out  1: registered; 1 while in LOCKED.
- `err_pulse`  out  1: registered one-cycle strobe per detected bit error.
- `err_count`  out  CNT_W: registered saturating count of errors since reset or clear.
- `state_o`  out  2: current FSM state (debug): 0=SEARCH, 1=VERIFY, 2=LOCKED.

## Operation
- History register `h[4:0]`, where h[0] is the newest bit. Prediction `p = h[4] ^ h[2]`. On each accepted bit, the history shifts left: h <= {h[3:0], x}.
- SEARCH: x = `bit_in`, and `fill` (0..5) increments, saturating at 5. When `fill`=5 and the post-shift history is nonzero, go to VERIFY with `match`=0. An all-zero history stays in SEARCH (lock-up state is never accepted).
- VERIFY: x = `bit_in`.
  - If `bit_in`==p: `match`++. When `match` reaches LOCK_CNT, go to LOCKED and clear `win` and `werr`.
  - If `bit_in`!=p: `match`=0 and stay in VERIFY. No `err_pulse` in this state.
- LOCKED: x = p, so the history free-runs from its own prediction and received errors do not propagate.
  - If `bit_in`!=p: assert `err_pulse`, increment `err_count` (saturating at 2^CNT_W-1), and increment `werr`.
  - `win` counts accepted bits 0..30. On the bit where `win`=30, `win` wraps to 0 and `werr` clears; an error on that same bit is counted in the closing window first.
  - If `werr` reaches UNLOCK_ERR: go to SEARCH, with `fill`=0 and `match`=0.
- `bit_valid`=0: no state, history or counter changes, and `err_pulse`=0.
- `clr_err`=1: `err_count` <= 0 and takes priority over a simultaneous increment. FSM state is unaffected.

## Timing
- Reset values: `locked`=0, `err_pulse`=0, `err_count`=0, `state_o`=0, `h`=0, and all internal counters 0.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronously). Relock then requires the full sequence again.
- Minimum lock latency with a clean stream and no gaps: 5 + LOCK_CNT accepted bits. `locked` rises on the clock edge that accepts bit number 5+LOCK_CNT, so it is visible in the following cycle.
- `err_pulse` is high for exactly the one cycle after the edge that accepts the errored bit.
- `err_count` updates on that same edge.
- Loss of lock: `locked` falls on the edge that accepts the UNLOCK_ERR-th error in a window. The `err_pulse` for that error is still asserted.
- Throughput: one bit per cycle, with no stall or backpressure.

## Test plan
- Clean stream from a generator seeded with 5'b00001, continuous valid: `locked`=1 after 13 accepted bits (LOCK_CNT=8) and stays high for 1000 bits. `err_count`=0 and `err_pulse` never asserts.
- While locked, invert one bit: exactly one `err_pulse` the cycle after that bit, `err_count`=1, `locked` stays 1. The next 31 bits produce no further pulses, so the single error does not multiply.
- While locked, invert 4 bits within one 31-bit window: 4 pulses, `locked`=0 after the 4th, `state_o`=0. Clean data afterwards relocks within 13 bits, and `err_count` holds at 4.
- Invert 3 bits at window positions 28, 29 and 30, then 1 bit at position 2 of the next window: `locked` stays 1 and `err_count`=4.
- All-zero input for 100 bits: `state_o` stays 0 and `locked`=0. Also, a clean stream with `bit_valid` toggling 1/0 every cycle locks after 13 valid bits (26 cycles).
- Three cases:
  - `nrst` pulsed low while locked with `err_count`=5: all outputs read 0 immediately.
  - `clr_err` asserted on the same cycle as an error: `err_count`=0 and `err_pulse`=1.
  - CNT_W=2 with 5 errors: `err_count` saturates at 3.

Source files
------------

// File: rtl/lfsr_5_checker.sv
// ---------------------------------------------------------------------------
// lfsr_5_checker
//
// Receive-side checker for the 5-bit m-sequence b[n] = b[n-5] ^ b[n-3]
// (x^5 + x^3 + 1, period 31). It fills a 5-bit history from the incoming
// serial stream, verifies that history against LOCK_CNT consecutive
// predictions, then free-runs a local copy of the sequence. While locked,
// every received bit that differs from the local sequence is flagged and
// counted. Lock is dropped when UNLOCK_ERR errors fall inside one 31-bit
// window.
//
// Parameters
//   LOCK_CNT    consecutive correct predictions needed to lock (1..31)
//   UNLOCK_ERR  errors within one 31-bit window that drop lock (1..31)
//   CNT_W       width of the saturating error counter
//
// Ports
//   clk        in   rising-edge clock
//   nrst       in   asynchronous active-low reset
//   bit_in     in   received sequence bit, sampled when bit_valid=1
//   bit_valid  in   qualifies bit_in; gaps allowed
//   clr_err    in   synchronous clear of err_count (wins over an increment)
//   locked     out  registered, 1 while in LOCKED
//   err_pulse  out  registered one-cycle strobe per detected bit error
//   err_count  out  registered saturating error count
//   state_o    out  FSM state: 0=SEARCH, 1=VERIFY, 2=LOCKED
// ---------------------------------------------------------------------------
module lfsr_5_checker #(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_ERR = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [4:0] LockCntC   = 5'(LOCK_CNT);
  localparam logic [4:0] UnlockErrC = 5'(UNLOCK_ERR);
  localparam logic [2:0] FillFullC  = 3'd5;
  localparam logic [4:0] WinLastC   = 5'd30;

  // Next sequence bit from the history: taps at b[n-5] and b[n-3].
  function automatic logic predict(input logic [4:0] hist);
    return hist[4] ^ hist[2];
  endfunction

  // Increment that holds at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value == {CNT_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

  state_t           state_r;
  logic [4:0]       hist_r;        // hist_r[0] is the newest bit
  logic [2:0]       fillCnt_r;     // bits collected in SEARCH, saturates at 5
  logic [4:0]       matchCnt_r;    // consecutive good predictions in VERIFY
  logic [4:0]       winPos_r;      // position of the next bit in the 31-bit window
  logic [4:0]       winErr_r;      // errors seen in the current window
  logic             locked_r;
  logic             errPulse_r;
  logic [CNT_W-1:0] errCount_r;

  logic             predBit_s;
  logic             shiftIn_s;
  logic [4:0]       histNext_s;
  logic [2:0]       fillNext_s;
  logic [4:0]       matchNext_s;
  logic [4:0]       winErrNext_s;
  logic             errBit_s;
  logic [CNT_W-1:0] errCountNext_s;

  // Prediction, shift input and counter increments shared by every state.
  always_comb begin
    predBit_s    = predict(hist_r);
    // Once locked the history follows its own prediction, so a corrupted
    // received bit never enters the local generator.
    shiftIn_s    = (state_r == LOCKED) ? predBit_s : bit_in;
    histNext_s   = {hist_r[3:0], shiftIn_s};
    fillNext_s   = (fillCnt_r == FillFullC) ? FillFullC : (fillCnt_r + 3'd1);
    matchNext_s  = matchCnt_r + 5'd1;
    errBit_s     = bit_valid & (state_r == LOCKED) & (bit_in != predBit_s);
    winErrNext_s = winErr_r + {4'd0, errBit_s};
  end

  // Error counter next value; a clear overrides a same-cycle increment.
  always_comb begin
    errCountNext_s = errCount_r;
    if (clr_err) begin
      errCountNext_s = {CNT_W{1'b0}};
    end else if (errBit_s) begin
      errCountNext_s = satInc(errCount_r);
    end else begin
      errCountNext_s = errCount_r;
    end
  end

  // Synchronisation FSM with its history, counters and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r     <= SEARCH;
      hist_r      <= 5'd0;
      fillCnt_r   <= 3'd0;
      matchCnt_r  <= 5'd0;
      winPos_r    <= 5'd0;
      winErr_r    <= 5'd0;
      locked_r    <= 1'b0;
      errPulse_r  <= 1'b0;
      errCount_r  <= {CNT_W{1'b0}};
    end else begin
      errPulse_r <= errBit_s;
      errCount_r <= errCountNext_s;
      if (bit_valid) begin
        hist_r <= histNext_s;
        case (state_r)
          SEARCH: begin
            fillCnt_r <= fillNext_s;
            // The all-zero history is the LFSR lock-up state and is never a
            // valid starting point.
            if ((fillNext_s == FillFullC) && (histNext_s != 5'd0)) begin
              state_r    <= VERIFY;
              matchCnt_r <= 5'd0;
            end else begin
              state_r    <= SEARCH;
            end
          end
          VERIFY: begin
            if (bit_in == predBit_s) begin
              if (matchNext_s == LockCntC) begin
                state_r    <= LOCKED;
                locked_r   <= 1'b1;
                matchCnt_r <= 5'd0;
                winPos_r   <= 5'd0;
                winErr_r   <= 5'd0;
              end else begin
                matchCnt_r <= matchNext_s;
              end
            end else begin
              matchCnt_r <= 5'd0;
            end
          end
          LOCKED: begin
            // The error on the last window bit is counted in the closing
            // window before the window counters restart.
            if (winErrNext_s >= UnlockErrC) begin
              state_r    <= SEARCH;
              locked_r   <= 1'b0;
              fillCnt_r  <= 3'd0;
              matchCnt_r <= 5'd0;
              winPos_r   <= 5'd0;
              winErr_r   <= 5'd0;
            end else if (winPos_r == WinLastC) begin
              winPos_r   <= 5'd0;
              winErr_r   <= 5'd0;
            end else begin
              winPos_r   <= winPos_r + 5'd1;
              winErr_r   <= winErrNext_s;
            end
          end
          default: begin
            state_r    <= SEARCH;
            locked_r   <= 1'b0;
            fillCnt_r  <= 3'd0;
            matchCnt_r <= 5'd0;
            winPos_r   <= 5'd0;
            winErr_r   <= 5'd0;
          end
        endcase
      end else begin
        hist_r <= hist_r;
      end
    end
  end

  assign locked    = locked_r;
  assign err_pulse = errPulse_r;
  assign err_count = errCount_r;
  assign state_o   = state_r;

  lfsr_5_checker_chk uChk (
    .clk       (clk),
    .nrst      (nrst),
    .bit_valid (bit_valid),
    .locked    (locked_r),
    .err_pulse (errPulse_r),
    .state_o   (state_r)
  );

endmodule

// ---------------------------------------------------------------------------
// lfsr_5_checker_chk
//
// Property checker for lfsr_5_checker outputs.
//
// Ports
//   clk, nrst  clock and asynchronous active-low reset
//   bit_valid  input qualifier of the checked block
//   locked     lock indicator
//   err_pulse  error strobe
//   state_o    FSM state encoding
// ---------------------------------------------------------------------------
module lfsr_5_checker_chk (
  input logic       clk,
  input logic       nrst,
  input logic       bit_valid,
  input logic       locked,
  input logic       err_pulse,
  input logic [1:0] state_o
);

  // The lock flag always agrees with the LOCKED encoding.
  a_lockedState: assert property (@(posedge clk) disable iff (!nrst)
    locked == (state_o == 2'd2));

  // Only the three defined states are ever reached.
  a_stateLegal: assert property (@(posedge clk) disable iff (!nrst)
    state_o != 2'd3);

  // An error strobe needs an accepted bit while locked on the edge before.
  a_pulseQualified: assert property (@(posedge clk) disable iff (!nrst)
    err_pulse |-> ($past(bit_valid) && $past(locked)));

endmodule
